// File: rtl/cpu6502_pkg.sv
// cpu6502_pkg: addressing-mode encoding plus per-mode instruction length and
// operand-read count tables, shared by the opcode decoder and addr_gen.
package cpu6502_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned MODE_W = 4;
  localparam int unsigned LEN_W  = 2;
  localparam int unsigned RCNT_W = 3;

  // Addressing modes as emitted by the opcode decoder; 4'hD/4'hE are unused.
  typedef enum logic [MODE_W-1:0] {
    AM_ACC  = 4'h0,
    AM_IMM  = 4'h1,
    AM_ZP   = 4'h2,
    AM_ZPX  = 4'h3,
    AM_ZPY  = 4'h4,
    AM_ABS  = 4'h5,
    AM_ABSX = 4'h6,
    AM_ABSY = 4'h7,
    AM_IND  = 4'h8,
    AM_INDX = 4'h9,
    AM_INDY = 4'hA,
    AM_IMP  = 4'hB,
    AM_REL  = 4'hC,
    AM_INV  = 4'hF
  } addr_mode_e;

  // Operand memory reads per mode.
  localparam logic [RCNT_W-1:0] RD_NONE = 3'd0;
  localparam logic [RCNT_W-1:0] RD_ONE  = 3'd1;
  localparam logic [RCNT_W-1:0] RD_TWO  = 3'd2;
  localparam logic [RCNT_W-1:0] RD_FOUR = 3'd4;

  // Instruction length in bytes.
  localparam logic [LEN_W-1:0] LEN_ONE   = 2'd1;
  localparam logic [LEN_W-1:0] LEN_TWO   = 2'd2;
  localparam logic [LEN_W-1:0] LEN_THREE = 2'd3;

  // True for every encoding the address generator understands.
  function automatic logic mode_valid(input logic [MODE_W-1:0] m);
    case (m)
      AM_ACC, AM_IMM, AM_ZP, AM_ZPX, AM_ZPY, AM_ABS, AM_ABSX, AM_ABSY,
      AM_IND, AM_INDX, AM_INDY, AM_IMP, AM_REL: mode_valid = 1'b1;
      default:                                  mode_valid = 1'b0;
    endcase
  endfunction

  // Number of operand-resolution memory reads.
  function automatic logic [RCNT_W-1:0] mode_reads(input logic [MODE_W-1:0] m);
    case (m)
      AM_IMM, AM_ZP, AM_ZPX, AM_ZPY, AM_REL: mode_reads = RD_ONE;
      AM_ABS, AM_ABSX, AM_ABSY:              mode_reads = RD_TWO;
      AM_IND, AM_INDX, AM_INDY:              mode_reads = RD_FOUR;
      default:                               mode_reads = RD_NONE;
    endcase
  endfunction

  // Instruction length including the opcode byte.
  function automatic logic [LEN_W-1:0] mode_len(input logic [MODE_W-1:0] m);
    case (m)
      AM_IMM, AM_ZP, AM_ZPX, AM_ZPY, AM_REL,
      AM_INDX, AM_INDY:                      mode_len = LEN_TWO;
      AM_ABS, AM_ABSX, AM_ABSY, AM_IND:      mode_len = LEN_THREE;
      default:                               mode_len = LEN_ONE;
    endcase
  endfunction

endpackage

// File: rtl/addr_gen.sv
// addr_gen: resolves the effective address / operand of the fetched
// instruction by walking operand and pointer bytes through memory.
//   clk, rst        clock, synchronous active-high reset
//   start           begin resolution (accepted only in IDLE)
//   mode, pc_in,    addressing mode, opcode address, index registers;
//   x, y            latched on an accepted start
//   mem_addr/mem_rd read request; mem_rdata returns one cycle later
//   busy, done      non-IDLE indicator, one-cycle completion pulse
//   ea, operand,    results, held from done until the next accepted start
//   pc_adv,
//   page_cross,
//   error
module addr_gen
  import cpu6502_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [MODE_W-1:0] mode,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ea,
  output logic [DATA_W-1:0] operand,
  output logic [LEN_W-1:0]  pc_adv,
  output logic              page_cross,
  output logic              error
);

  typedef enum logic [3:0] {
    IDLE, RD_LO, CAP_LO, RD_HI, CAP_HI,
    PTR_LO_RD, PTR_LO_CAP, PTR_HI_RD, PTR_HI_CAP, DONE
  } state_e;

  state_e              state_q, state_nxt;
  logic [MODE_W-1:0]   mode_q, mode_nxt;
  logic [DATA_W-1:0]   x_q, x_nxt, y_q, y_nxt;
  logic [DATA_W-1:0]   b1_q, b1_nxt, ptr_lo_q, ptr_lo_nxt;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_nxt;
  logic                mem_rd_q, mem_rd_nxt;
  logic                busy_q, busy_nxt, done_q, done_nxt;
  logic [ADDR_W-1:0]   ea_q, ea_nxt;
  logic [DATA_W-1:0]   operand_q, operand_nxt;
  logic [LEN_W-1:0]    pc_adv_q, pc_adv_nxt;
  logic                page_cross_q, page_cross_nxt;
  logic                error_q, error_nxt;

  logic [DATA_W-1:0]   idx;
  logic [ADDR_W-1:0]   add_a, add_b, sum;
  logic                add_ci, carry8;

  assign idx = (mode_q == AM_ZPY || mode_q == AM_ABSY || mode_q == AM_INDY) ? y_q : x_q;

  // Operand select for the single shared 16-bit adder, keyed on the state being left.
  always_comb begin : adder_operands
    add_a  = '0;
    add_b  = '0;
    add_ci = 1'b0;
    case (state_q)
      IDLE: begin
        add_a  = pc_in;
        add_ci = 1'b1;
      end
      CAP_LO: begin
        if (mode_q == AM_ZPX || mode_q == AM_ZPY) begin
          add_a = {8'h00, mem_rdata};
          add_b = {8'h00, idx};
        end else if (mode_q == AM_REL) begin
          // mem_addr_q still holds pc+1, so pc+2+sext(b1) needs only the carry-in
          add_a  = mem_addr_q;
          add_b  = {{8{mem_rdata[7]}}, mem_rdata};
          add_ci = 1'b1;
        end else begin
          add_a  = mem_addr_q;
          add_ci = 1'b1;
        end
      end
      CAP_HI: begin
        if (mode_q == AM_INDX) begin
          add_a = {8'h00, b1_q};
          add_b = {8'h00, x_q};
        end else begin
          add_a = {mem_rdata, b1_q};
          add_b = {8'h00, idx};
        end
      end
      PTR_LO_CAP: begin
        add_a  = mem_addr_q;
        add_ci = 1'b1;
      end
      PTR_HI_CAP: begin
        add_a = {mem_rdata, ptr_lo_q};
        add_b = {8'h00, y_q};
      end
      default: ;
    endcase
  end

  assign sum    = add_a + add_b + ADDR_W'(add_ci);
  // Carry out of the low byte, recovered from bit 8 of the full sum.
  assign carry8 = sum[8] ^ add_a[8] ^ add_b[8];

  // Next-state and registered-output logic.
  always_comb begin : fsm_next
    state_nxt      = state_q;
    mode_nxt       = mode_q;
    x_nxt          = x_q;
    y_nxt          = y_q;
    b1_nxt         = b1_q;
    ptr_lo_nxt     = ptr_lo_q;
    mem_addr_nxt   = mem_addr_q;
    ea_nxt         = ea_q;
    operand_nxt    = operand_q;
    pc_adv_nxt     = pc_adv_q;
    page_cross_nxt = page_cross_q;
    error_nxt      = error_q;
    mem_rd_nxt     = 1'b0;
    busy_nxt       = 1'b0;
    done_nxt       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          mode_nxt = mode;
          x_nxt    = x;
          y_nxt    = y;
          if (mode_reads(mode) == RD_NONE) begin
            state_nxt      = DONE;
            ea_nxt         = '0;
            operand_nxt    = '0;
            pc_adv_nxt     = mode_len(mode);
            page_cross_nxt = 1'b0;
            error_nxt      = ~mode_valid(mode);
          end else begin
            state_nxt    = RD_LO;
            mem_addr_nxt = sum;
          end
        end
      end
      RD_LO: state_nxt = CAP_LO;
      CAP_LO: begin
        b1_nxt = mem_rdata;
        if (mode_reads(mode_q) == RD_ONE) begin
          state_nxt      = DONE;
          pc_adv_nxt     = mode_len(mode_q);
          page_cross_nxt = 1'b0;
          error_nxt      = 1'b0;
          operand_nxt    = (mode_q == AM_IMM || mode_q == AM_REL) ? mem_rdata : '0;
          case (mode_q)
            AM_IMM:         ea_nxt = mem_addr_q;
            AM_ZP:          ea_nxt = {8'h00, mem_rdata};
            AM_ZPX, AM_ZPY: ea_nxt = {8'h00, sum[7:0]};
            default:        ea_nxt = sum;
          endcase
        end else begin
          // Second operand byte at pc+2; for the zero-page indirect modes it is a dummy read.
          state_nxt    = RD_HI;
          mem_addr_nxt = sum;
        end
      end
      RD_HI: state_nxt = CAP_HI;
      CAP_HI: begin
        if (mode_reads(mode_q) == RD_TWO) begin
          state_nxt      = DONE;
          pc_adv_nxt     = mode_len(mode_q);
          error_nxt      = 1'b0;
          operand_nxt    = '0;
          ea_nxt         = (mode_q == AM_ABS) ? {mem_rdata, b1_q} : sum;
          page_cross_nxt = (mode_q != AM_ABS) && carry8;
        end else begin
          state_nxt = PTR_LO_RD;
          case (mode_q)
            AM_IND:  mem_addr_nxt = {mem_rdata, b1_q};
            AM_INDX: mem_addr_nxt = {8'h00, sum[7:0]};
            default: mem_addr_nxt = {8'h00, b1_q};
          endcase
        end
      end
      PTR_LO_RD: state_nxt = PTR_LO_CAP;
      PTR_LO_CAP: begin
        ptr_lo_nxt   = mem_rdata;
        state_nxt    = PTR_HI_RD;
        // Increment only the low byte: pointer fetch never carries into the page.
        mem_addr_nxt = {mem_addr_q[15:8], sum[7:0]};
      end
      PTR_HI_RD: state_nxt = PTR_HI_CAP;
      PTR_HI_CAP: begin
        state_nxt      = DONE;
        pc_adv_nxt     = mode_len(mode_q);
        error_nxt      = 1'b0;
        operand_nxt    = '0;
        ea_nxt         = (mode_q == AM_INDY) ? sum : {mem_rdata, ptr_lo_q};
        page_cross_nxt = (mode_q == AM_INDY) && carry8;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    mem_rd_nxt = (state_nxt == RD_LO) || (state_nxt == RD_HI) ||
                 (state_nxt == PTR_LO_RD) || (state_nxt == PTR_HI_RD);
    busy_nxt   = (state_nxt != IDLE);
    done_nxt   = (state_nxt == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mode_q       <= '0;
      x_q          <= '0;
      y_q          <= '0;
      b1_q         <= '0;
      ptr_lo_q     <= '0;
      mem_addr_q   <= '0;
      mem_rd_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ea_q         <= '0;
      operand_q    <= '0;
      pc_adv_q     <= '0;
      page_cross_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      mode_q       <= mode_nxt;
      x_q          <= x_nxt;
      y_q          <= y_nxt;
      b1_q         <= b1_nxt;
      ptr_lo_q     <= ptr_lo_nxt;
      mem_addr_q   <= mem_addr_nxt;
      mem_rd_q     <= mem_rd_nxt;
      busy_q       <= busy_nxt;
      done_q       <= done_nxt;
      ea_q         <= ea_nxt;
      operand_q    <= operand_nxt;
      pc_adv_q     <= pc_adv_nxt;
      page_cross_q <= page_cross_nxt;
      error_q      <= error_nxt;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_rd     = mem_rd_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign ea         = ea_q;
  assign operand    = operand_q;
  assign pc_adv     = pc_adv_q;
  assign page_cross = page_cross_q;
  assign error      = error_q;

endmodule

// File: tb/tb_addr_gen.sv
// tb_addr_gen: directed and random operand-resolution runs against a
// byte-wide memory model, with a scoreboard of expected results.
module tb_addr_gen;
  import cpu6502_pkg::*;

  logic        clk, rst, start;
  logic [3:0]  mode;
  logic [15:0] pc_in;
  logic [7:0]  x, y;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic        busy, done;
  logic [15:0] ea;
  logic [7:0]  operand;
  logic [1:0]  pc_adv;
  logic        page_cross, error;

  typedef struct {
    string       tag;
    logic [15:0] ea;
    logic [7:0]  operand;
    logic [1:0]  len;
    logic        pcross;
    logic        err;
    int          reads;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] mem [0:65535];
  int         vectors = 0;
  int         miscompares = 0;
  int         rd_total = 0;
  int         rd_mark = 0;

  addr_gen dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .pc_in(pc_in),
    .x(x), .y(y), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .ea(ea), .operand(operand), .pc_adv(pc_adv),
    .page_cross(page_cross), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read data valid exactly one cycle after the strobe; noise otherwise.
  always @(posedge clk) begin
    if (mem_rd) begin
      mem_rdata <= mem[mem_addr];
      rd_total  <= rd_total + 1;
    end else begin
      mem_rdata <= 8'($urandom);
    end
  end

  // Reference behaviour of each addressing mode, from the current memory image.
  function automatic exp_t model(input logic [3:0] m, input logic [15:0] pc,
                                 input logic [7:0] xi, input logic [7:0] yi);
    exp_t        r;
    logic [7:0]  b1, b2, lo, hi, zp;
    logic [15:0] p, base;
    logic [8:0]  lsum;
    b1 = mem[pc + 16'd1];
    b2 = mem[pc + 16'd2];
    r.tag = ""; r.ea = 16'h0; r.operand = 8'h0; r.len = 2'd1;
    r.pcross = 1'b0; r.err = 1'b0; r.reads = 0;
    case (m)
      4'h0, 4'hB: begin r.len = 2'd1; r.reads = 0; end
      4'h1: begin r.ea = pc + 16'd1; r.operand = b1; r.len = 2'd2; r.reads = 1; end
      4'h2: begin r.ea = {8'h00, b1}; r.len = 2'd2; r.reads = 1; end
      4'h3: begin zp = b1 + xi; r.ea = {8'h00, zp}; r.len = 2'd2; r.reads = 1; end
      4'h4: begin zp = b1 + yi; r.ea = {8'h00, zp}; r.len = 2'd2; r.reads = 1; end
      4'h5: begin r.ea = {b2, b1}; r.len = 2'd3; r.reads = 2; end
      4'h6, 4'h7: begin
        lsum = {1'b0, b1} + {1'b0, (m == 4'h6) ? xi : yi};
        r.ea = {b2, b1} + {8'h00, (m == 4'h6) ? xi : yi};
        r.pcross = lsum[8]; r.len = 2'd3; r.reads = 2;
      end
      4'h8: begin
        p = {b2, b1}; lo = mem[p]; zp = p[7:0] + 8'd1; hi = mem[{p[15:8], zp}];
        r.ea = {hi, lo}; r.len = 2'd3; r.reads = 4;
      end
      4'h9: begin
        zp = b1 + xi; lo = mem[{8'h00, zp}]; zp = zp + 8'd1; hi = mem[{8'h00, zp}];
        r.ea = {hi, lo}; r.len = 2'd2; r.reads = 4;
      end
      4'hA: begin
        lo = mem[{8'h00, b1}]; zp = b1 + 8'd1; hi = mem[{8'h00, zp}];
        base = {hi, lo}; lsum = {1'b0, lo} + {1'b0, yi};
        r.ea = base + {8'h00, yi}; r.pcross = lsum[8]; r.len = 2'd2; r.reads = 4;
      end
      4'hC: begin
        r.ea = pc + 16'd2 + {{8{b1[7]}}, b1}; r.operand = b1; r.len = 2'd2; r.reads = 1;
      end
      default: begin r.err = 1'b1; r.len = 2'd1; r.reads = 0; end
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a start for one cycle; push the model's expectation.
  task automatic start_op(input string tag, input logic [3:0] m, input logic [15:0] pc,
                          input logic [7:0] xi, input logic [7:0] yi, input bit hold);
    exp_t e;
    @(negedge clk);
    start = 1'b1; mode = m; pc_in = pc; x = xi; y = yi;
    e = model(m, pc, xi, yi);
    e.tag = tag;
    sbq.push_back(e);
    rd_mark = rd_total;
    @(posedge clk); #1;
    if (!hold) begin
      start = 1'b0; mode = 4'($urandom); pc_in = 16'($urandom);
      x = 8'($urandom); y = 8'($urandom);
    end
  endtask

  // Wait (bounded) for done, then compare against the oldest expectation.
  task automatic wait_check();
    exp_t e;
    int   n = 1;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    e = sbq.pop_front();
    check({e.tag, " done_cycle"}, 32'(n), 32'(1 + 2 * e.reads));
    check({e.tag, " reads"}, 32'(rd_total - rd_mark), 32'(e.reads));
    check({e.tag, " ea"}, 32'(ea), 32'(e.ea));
    check({e.tag, " operand"}, 32'(operand), 32'(e.operand));
    check({e.tag, " pc_adv"}, 32'(pc_adv), 32'(e.len));
    check({e.tag, " page_cross"}, 32'(page_cross), 32'(e.pcross));
    check({e.tag, " error"}, 32'(error), 32'(e.err));
    @(posedge clk); #1;
    check({e.tag, " done_pulse"}, 32'(done), 32'(0));
    check({e.tag, " idle"}, 32'(busy), 32'(0));
    check({e.tag, " ea_hold"}, 32'(ea), 32'(e.ea));
  endtask

  initial begin
    exp_t e_drop;
    bit   saw_done;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    rst = 1'b1; start = 1'b0; mode = 4'h0; pc_in = 16'h0; x = 8'h0; y = 8'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", 32'(busy), 32'(0));
    check("rst done", 32'(done), 32'(0));
    check("rst mem_rd", 32'(mem_rd), 32'(0));
    check("rst mem_addr", 32'(mem_addr), 32'(0));
    check("rst ea", 32'(ea), 32'(0));
    check("rst operand", 32'(operand), 32'(0));
    check("rst pc_adv", 32'(pc_adv), 32'(0));
    check("rst page_cross", 32'(page_cross), 32'(0));
    check("rst error", 32'(error), 32'(0));
    rst = 1'b0;

    // zp,X wraps within page zero
    mem[16'h0201] = 8'h80;
    start_op("zpx_wrap", 4'h3, 16'h0200, 8'hFF, 8'h00, 1'b0);
    wait_check();
    check("zpx_wrap ea_const", 32'(ea), 32'h007F);

    // abs,Y crosses into the next page
    mem[16'h0301] = 8'hF0; mem[16'h0302] = 8'h12;
    start_op("absy_cross", 4'h7, 16'h0300, 8'h00, 8'h20, 1'b0);
    wait_check();
    check("absy_cross ea_const", 32'(ea), 32'h1310);
    check("absy_cross pc_const", 32'(page_cross), 32'(1));

    // indirect pointer high byte fetched without page carry
    mem[16'h0501] = 8'hFF; mem[16'h0502] = 8'h10;
    mem[16'h10FF] = 8'h34; mem[16'h1000] = 8'h12; mem[16'h1100] = 8'hEE;
    start_op("ind_bug", 4'h8, 16'h0500, 8'h00, 8'h00, 1'b0);
    wait_check();
    check("ind_bug ea_const", 32'(ea), 32'h1234);

    // relative branch backwards
    mem[16'h0401] = 8'hFE;
    start_op("rel_neg", 4'hC, 16'h0400, 8'h00, 8'h00, 1'b0);
    wait_check();
    check("rel_neg ea_const", 32'(ea), 32'h0400);
    check("rel_neg operand_const", 32'(operand), 32'h00FE);

    // (ind,X) pointer wraps at zero-page end
    mem[16'h0601] = 8'hFE; mem[16'h00FF] = 8'hCD; mem[16'h0000] = 8'hAB;
    start_op("indx_wrap", 4'h9, 16'h0600, 8'h01, 8'h00, 1'b0);
    wait_check();
    check("indx_wrap ea_const", 32'(ea), 32'hABCD);

    // (ind),Y with carry
    mem[16'h0701] = 8'h40; mem[16'h0040] = 8'hF0; mem[16'h0041] = 8'h33;
    start_op("indy_cross", 4'hA, 16'h0700, 8'h00, 8'h10, 1'b0);
    wait_check();
    check("indy_cross ea_const", 32'(ea), 32'h3400);

    // start held high: second op accepted right after the return to IDLE
    mem[16'h0A01] = 8'h55;
    start_op("hold1", 4'h2, 16'h0A00, 8'h00, 8'h00, 1'b1);
    wait_check();
    e_drop = model(4'h2, 16'h0A00, 8'h00, 8'h00);
    e_drop.tag = "hold2";
    sbq.push_back(e_drop);
    rd_mark = rd_total;
    @(posedge clk); #1;
    start = 1'b0;
    check("hold2 accepted", 32'(busy), 32'(1));
    wait_check();

    // random modes, including unlisted encodings
    for (int i = 0; i < 24; i++) begin
      start_op($sformatf("rnd%0d", i), 4'($urandom), 16'($urandom),
               8'($urandom), 8'($urandom), 1'b0);
      wait_check();
    end

    // invalid mode, then reset in the middle of an abs operation
    start_op("invalid", 4'hF, 16'h0800, 8'h00, 8'h00, 1'b0);
    wait_check();
    check("invalid error_held", 32'(error), 32'(1));
    start_op("abs_rst", 4'h5, 16'h0900, 8'h00, 8'h00, 1'b0);
    e_drop = sbq.pop_front();
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b1; mode = 4'h5;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    check("midrst busy", 32'(busy), 32'(0));
    check("midrst mem_rd", 32'(mem_rd), 32'(0));
    check("midrst error", 32'(error), 32'(0));
    check("midrst ea", 32'(ea), 32'(0));
    check("midrst pc_adv", 32'(pc_adv), 32'(0));
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
      @(posedge clk); #1;
    end
    check("midrst no_done", 32'(saw_done), 32'(0));

    // start in the same cycle as reset is ignored
    @(negedge clk);
    rst = 1'b1; start = 1'b1; mode = 4'h2;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    check("rst_start ignored", 32'(busy), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
